// File: rtl/answer_judge_if.sv
// Player-side bus of the quiz judge: raw buttons and the expected answer in,
// question index, ownership, entry, scores and verdict out.
interface answer_judge_if;
  logic       btn_buzz_p1;
  logic       btn_buzz_p2;
  logic       btn_count;
  logic       btn_lock;
  logic [3:0] bcd_ans;
  logic [3:0] bcd_state;
  logic [1:0] owner;
  logic [3:0] entry;
  logic [2:0] score_p1;
  logic [2:0] score_p2;
  logic [4:0] led_p1;
  logic [4:0] led_p2;
  logic       result_valid;
  logic       result_correct;
  logic       game_over;

  // Driver side: buttons and the question ROM answer.
  modport master (
    output btn_buzz_p1, btn_buzz_p2, btn_count, btn_lock, bcd_ans,
    input  bcd_state, owner, entry, score_p1, score_p2, led_p1, led_p2,
    input  result_valid, result_correct, game_over
  );

  // Judge side.
  modport slave (
    input  btn_buzz_p1, btn_buzz_p2, btn_count, btn_lock, bcd_ans,
    output bcd_state, owner, entry, score_p1, score_p2, led_p1, led_p2,
    output result_valid, result_correct, game_over
  );
endinterface

// File: rtl/answer_judge.sv
// Quiz answer judge: synchronizes and debounces four raw buttons, arbitrates
// the buzzer, collects the entered answer, judges it and keeps the scores.
module answer_judge #(
  parameter int DEBOUNCE_CYC  = 4,
  parameter int TIMEOUT_CYC   = 1000,
  parameter int NUM_QUESTIONS = 11
) (
  input  logic          clk,
  input  logic          reset,
  answer_judge_if.slave bus
);

  localparam int BTN_N  = 4;
  localparam int B_P1   = 0;
  localparam int B_P2   = 1;
  localparam int B_CNT  = 2;
  localparam int B_LOCK = 3;

  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYC - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  Q_LAST    = 4'(NUM_QUESTIONS - 1);
  localparam logic [2:0]  SCORE_MAX = 3'd5;
  localparam logic [3:0]  ENTRY_MAX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ANSWER,
    S_JUDGE,
    S_NEXT,
    S_OVER
  } state_t;

  // ---------------------------------------------------------------------------
  // Button front end
  // ---------------------------------------------------------------------------
  logic [BTN_N-1:0] raw;
  logic [BTN_N-1:0] sync_a;
  logic [BTN_N-1:0] sync_b;
  logic [BTN_N-1:0] level;
  logic [BTN_N-1:0] armed;
  logic [BTN_N-1:0] press;
  logic [1:0]       primed;
  logic [7:0]       db_cnt [BTN_N];

  assign raw = {bus.btn_lock, bus.btn_count, bus.btn_buzz_p2, bus.btn_buzz_p1};

  // Two-flop synchronizer, debounce counter and press-pulse generation per button.
  // A button only becomes armed once it has been seen released after reset, so
  // a button held through reset never produces a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      level  <= '0;
      armed  <= '0;
      press  <= '0;
      primed <= '0;
      // NOTE: db_cnt is a handful of flops, not a RAM, so it is cleared in reset
      // like any other register; a real memory would be left out of reset.
      for (int i = 0; i < BTN_N; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values; sync_b therefore lags sync_a by one cycle.
      sync_a <= raw;
      sync_b <= sync_a;
      primed <= {primed[0], 1'b1};
      for (int i = 0; i < BTN_N; i++) begin
        press[i] <= 1'b0;
        if (primed[1] && !sync_b[i]) begin
          armed[i] <= 1'b1;
        end
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync_b[i];
          press[i]  <= sync_b[i] & armed[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [3:0]  bcd_state;
  logic [1:0]  owner;
  logic [3:0]  entry;
  logic [2:0]  score_p1;
  logic [2:0]  score_p2;
  logic        result_valid;
  logic        result_correct;
  logic        game_over;
  logic [15:0] tcnt;
  logic        timed_out;
  logic        judge_ok;

  assign judge_ok = (entry == bus.bcd_ans) && !timed_out;

  // Buzz arbitration, answer entry with timeout, verdict and question advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      bcd_state      <= '0;
      owner          <= '0;
      entry          <= '0;
      score_p1       <= '0;
      score_p2       <= '0;
      result_valid   <= 1'b0;
      result_correct <= 1'b0;
      game_over      <= 1'b0;
      tcnt           <= '0;
      timed_out      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press[B_P1] || press[B_P2]) begin
            owner     <= press[B_P1] ? 2'b01 : 2'b10;
            entry     <= '0;
            tcnt      <= '0;
            timed_out <= 1'b0;
            state     <= S_ANSWER;
          end
        end
        S_ANSWER: begin
          if (press[B_CNT] && entry != ENTRY_MAX) begin
            entry <= entry + 4'd1;
          end
          tcnt <= tcnt + 16'd1;
          if (press[B_LOCK]) begin
            timed_out <= 1'b0;
            state     <= S_JUDGE;
          end else if (tcnt == TO_LAST) begin
            timed_out <= 1'b1;
            state     <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          result_valid   <= 1'b1;
          result_correct <= judge_ok;
          if (judge_ok) begin
            if (owner == 2'b01 && score_p1 != SCORE_MAX) begin
              score_p1 <= score_p1 + 3'd1;
            end
            if (owner == 2'b10 && score_p2 != SCORE_MAX) begin
              score_p2 <= score_p2 + 3'd1;
            end
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          owner <= '0;
          if (bcd_state == Q_LAST || score_p1 == SCORE_MAX || score_p2 == SCORE_MAX) begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            bcd_state <= bcd_state + 4'd1;
            state     <= S_IDLE;
          end
        end
        S_OVER: begin
          owner <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Thermometer decode of a 0..5 score onto five LEDs.
  function automatic logic [4:0] thermo(input logic [2:0] s);
    // NOTE: every path of this case assigns the result (including default), so
    // the combinational decode can never infer a latch.
    case (s)
      3'd0:    thermo = 5'b00000;
      3'd1:    thermo = 5'b00001;
      3'd2:    thermo = 5'b00011;
      3'd3:    thermo = 5'b00111;
      3'd4:    thermo = 5'b01111;
      default: thermo = 5'b11111;
    endcase
  endfunction

  assign bus.bcd_state      = bcd_state;
  assign bus.owner          = owner;
  assign bus.entry          = entry;
  assign bus.score_p1       = score_p1;
  assign bus.score_p2       = score_p2;
  assign bus.led_p1         = thermo(score_p1);
  assign bus.led_p2         = thermo(score_p2);
  assign bus.result_valid   = result_valid;
  assign bus.result_correct = result_correct;
  assign bus.game_over      = game_over;

endmodule
